// File: rtl/secuenciador_muestreo.sv
// rtl/secuenciador_muestreo.sv - sample-rate sequencer for the 12-bit filter datapath
//
// Once per sample period it requests one ADC conversion, captures the result,
// pulses the delay-chain load enable, clears the MAC, steps it through N_TAPS
// taps and flags the filter output valid.
//
// Parameters:
//   W       sample width (ADC_Data, Dato_Reg)
//   DIV     CLK cycles per sample period (>= N_TAPS+8)
//   N_TAPS  taps sequenced per sample (>= 2)
//   TO      ADC timeout in cycles (only with ADC_TIMEOUT_EN)
//
// Ports:
//   CLK            in   system clock, rising edge
//   Reset          in   synchronous, active-high
//   Run            in   1 = periodic sampling enabled
//   ADC_Done       in   conversion complete, 1-cycle pulse
//   ADC_Data       in   sample, valid while ADC_Done=1
//   ADC_Start      out  conversion request (level, held during CONV)
//   Enable_Reg     out  1-cycle load pulse to the register chain
//   Dato_Reg       out  captured sample feeding the chain input
//   Tap_Sel        out  tap index for the MAC
//   MAC_Clear      out  1-cycle accumulator clear
//   MAC_En         out  accumulate enable
//   Salida_Valida  out  1-cycle result-valid pulse
//   Overrun        out  sticky: a sample tick arrived while not waiting for it
//   Busy           out  1 in any state except IDLE/ESPERA
//   ADC_Error      out  sticky ADC timeout flag (only with ADC_TIMEOUT_EN)
//
// Optional feature: define ADC_TIMEOUT_EN to abandon a conversion after TO
// cycles without ADC_Done and report it on ADC_Error.

module secuenciador_muestreo #(
  parameter int W      = 12,
  parameter int DIV    = 1000,
  parameter int N_TAPS = 4,
  parameter int TO     = 64
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      Run,
  input  logic                      ADC_Done,
  input  logic [W-1:0]              ADC_Data,
  output logic                      ADC_Start,
  output logic                      Enable_Reg,
  output logic [W-1:0]              Dato_Reg,
  output logic [$clog2(N_TAPS)-1:0] Tap_Sel,
  output logic                      MAC_Clear,
  output logic                      MAC_En,
  output logic                      Salida_Valida,
  output logic                      Overrun,
  output logic                      Busy
`ifdef ADC_TIMEOUT_EN
  ,
  output logic                      ADC_Error
`endif
);

  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(N_TAPS);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ESPERA   = 3'd1;
  localparam logic [2:0] CONV     = 3'd2;
  localparam logic [2:0] DESPLAZA = 3'd3;
  localparam logic [2:0] LIMPIA   = 3'd4;
  localparam logic [2:0] MAC      = 3'd5;
  localparam logic [2:0] FIN      = 3'd6;

  logic [2:0]    estado;
  logic [2:0]    estado_sig;
  logic [CW-1:0] cuenta;
  logic          tick;
  logic          captura;

`ifdef ADC_TIMEOUT_EN
  localparam int TOW = $clog2(TO);
  logic [TOW-1:0] cuenta_to;
  logic           expira;
`endif

  // The tick only exists while counting; with Run low the counter sits at 0.
  assign tick = Run && (cuenta == CW'(DIV - 1));

  always_comb begin
    estado_sig = estado;
    captura    = 1'b0;
`ifdef ADC_TIMEOUT_EN
    expira     = 1'b0;
`endif
    case (estado)
      IDLE: begin
        if (Run) estado_sig = ESPERA;
      end
      ESPERA: begin
        if (!Run)      estado_sig = IDLE;
        else if (tick) estado_sig = CONV;
      end
      CONV: begin
        if (ADC_Done) begin
          captura    = 1'b1;
          estado_sig = DESPLAZA;
        end
`ifdef ADC_TIMEOUT_EN
        else if (cuenta_to == TOW'(TO - 1)) begin
          // Give up on this sample; the next tick retries the conversion.
          expira     = 1'b1;
          estado_sig = ESPERA;
        end
`endif
      end
      DESPLAZA: estado_sig = LIMPIA;
      LIMPIA:   estado_sig = MAC;
      MAC: begin
        if (Tap_Sel == TW'(N_TAPS - 1)) estado_sig = FIN;
      end
      FIN: begin
        // Run is only honoured here, so a started sample always completes.
        estado_sig = Run ? ESPERA : IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a flop that
  // lines up exactly with the state it belongs to.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      estado        <= IDLE;
      cuenta        <= '0;
      Dato_Reg      <= '0;
      Tap_Sel       <= '0;
      ADC_Start     <= 1'b0;
      Enable_Reg    <= 1'b0;
      MAC_Clear     <= 1'b0;
      MAC_En        <= 1'b0;
      Salida_Valida <= 1'b0;
      Overrun       <= 1'b0;
      Busy          <= 1'b0;
`ifdef ADC_TIMEOUT_EN
      cuenta_to     <= '0;
      ADC_Error     <= 1'b0;
`endif
    end else begin
      estado <= estado_sig;

      if (!Run)                            cuenta <= '0;
      else if (cuenta == CW'(DIV - 1))     cuenta <= '0;
      else                                 cuenta <= cuenta + CW'(1);

      if (captura) Dato_Reg <= ADC_Data;

      // A tick is only consumed in ESPERA; anywhere else it is lost.
      if (tick && (estado != ESPERA)) Overrun <= 1'b1;

      Tap_Sel       <= (estado == MAC && estado_sig == MAC) ? Tap_Sel + TW'(1) : '0;
      ADC_Start     <= (estado_sig == CONV);
      Enable_Reg    <= (estado_sig == DESPLAZA);
      MAC_Clear     <= (estado_sig == LIMPIA);
      MAC_En        <= (estado_sig == MAC);
      Salida_Valida <= (estado_sig == FIN);
      Busy          <= !((estado_sig == IDLE) || (estado_sig == ESPERA));

`ifdef ADC_TIMEOUT_EN
      cuenta_to <= (estado == CONV && estado_sig == CONV) ? cuenta_to + TOW'(1) : '0;
      if (expira) ADC_Error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_secuenciador_muestreo.sv
// tb/tb_secuenciador_muestreo.sv - randomized self-checking bench for secuenciador_muestreo

module tb_secuenciador_muestreo;

  localparam int W      = 12;
  localparam int DIV    = 1000;
  localparam int N_TAPS = 4;
  localparam int TO     = 64;
  localparam int TW     = $clog2(N_TAPS);
  localparam int LAST   = N_TAPS + 3;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          Run = 1'b0;
  logic          ADC_Done = 1'b0;
  logic [W-1:0]  ADC_Data = '0;
  logic          ADC_Start;
  logic          Enable_Reg;
  logic [W-1:0]  Dato_Reg;
  logic [TW-1:0] Tap_Sel;
  logic          MAC_Clear;
  logic          MAC_En;
  logic          Salida_Valida;
  logic          Overrun;
  logic          Busy;
`ifdef ADC_TIMEOUT_EN
  logic          ADC_Error;
`endif

  always #5 CLK = ~CLK;

  secuenciador_muestreo #(.W(W), .DIV(DIV), .N_TAPS(N_TAPS), .TO(TO)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .Run           (Run),
    .ADC_Done      (ADC_Done),
    .ADC_Data      (ADC_Data),
    .ADC_Start     (ADC_Start),
    .Enable_Reg    (Enable_Reg),
    .Dato_Reg      (Dato_Reg),
    .Tap_Sel       (Tap_Sel),
    .MAC_Clear     (MAC_Clear),
    .MAC_En        (MAC_En),
    .Salida_Valida (Salida_Valida),
    .Overrun       (Overrun),
    .Busy          (Busy)
`ifdef ADC_TIMEOUT_EN
    ,
    .ADC_Error     (ADC_Error)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Reference model: m_post counts cycles since the capture (1 = load pulse,
  // 2 = clear, 3..LAST-1 = taps, LAST = valid). m_en means sampling is armed.
  bit           m_ok = 0;
  bit           m_en, m_conv, m_ovr, m_err;
  int           m_post, m_cnt, m_to;
  logic [W-1:0] m_dato;

  always @(posedge CLK) begin : model
    bit tick, waiting;
    if (Reset) begin
      m_ok = 1; m_en = 0; m_conv = 0; m_post = 0; m_cnt = 0; m_to = 0;
      m_ovr = 0; m_err = 0; m_dato = '0;
    end else begin
      tick    = Run && (m_cnt == DIV - 1);
      waiting = m_en && !m_conv && (m_post == 0);
      if (tick && !waiting) m_ovr = 1;
      if (m_conv) begin
        if (ADC_Done) begin
          m_dato = ADC_Data; m_conv = 0; m_post = 1;
        end
`ifdef ADC_TIMEOUT_EN
        else if (m_to == TO - 1) begin
          m_conv = 0; m_err = 1;
        end else m_to++;
`endif
      end else if (m_post > 0) begin
        if (m_post == LAST) begin
          m_post = 0; m_en = Run;
        end else m_post++;
      end else if (m_en) begin
        if (!Run) m_en = 0;
        else if (tick) begin
          m_conv = 1; m_to = 0;
        end
      end else if (Run) m_en = 1;
      m_cnt = Run ? (m_cnt + 1) % DIV : 0;
    end
  end

  always @(negedge CLK) begin : compare
    logic [W+TW+6:0] got, want;
    int et;
    if (m_ok) begin
      et   = (m_post >= 3 && m_post < LAST) ? m_post - 3 : 0;
      got  = {ADC_Start, Enable_Reg, MAC_Clear, MAC_En, Salida_Valida, Busy, Overrun, Tap_Sel, Dato_Reg};
      want = {m_conv, m_post == 1, m_post == 2, (m_post >= 3 && m_post < LAST), m_post == LAST,
              (m_conv || m_post > 0), m_ovr, TW'(et), m_dato};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle_compare cycle %0d: got %h expected %h", cyc, got, want);
      end
`ifdef ADC_TIMEOUT_EN
      checks++;
      if (ADC_Error !== m_err) begin
        errors++;
        $display("FAIL adc_error cycle %0d: got %b expected %b", cyc, ADC_Error, m_err);
      end
`endif
    end
  end

  // Event log used by the hand-computed checks.
  int en_q[$], tap_q[$], st_q[$], done_q[$];
  bit prev_start = 0;

  always @(negedge CLK) begin : monitor
    if (Enable_Reg) en_q.push_back(cyc);
    if (MAC_En) tap_q.push_back(int'(Tap_Sel));
    if (ADC_Start && !prev_start) st_q.push_back(cyc);
    prev_start = ADC_Start;
  end

  // ADC stand-in: answers resp_delay cycles after ADC_Start rises (0 = never).
  int           resp_delay = 5;
  bit           resp_spurious = 0;
  logic [W-1:0] data_q[$];

  initial begin : responder
    int wait_cnt;
    bit served;
    wait_cnt = 0;
    served   = 0;
    forever begin
      @(negedge CLK);
      ADC_Done = 1'b0;
      if (ADC_Start && !served) begin
        wait_cnt++;
        if (resp_delay > 0 && wait_cnt == resp_delay + 1) begin
          ADC_Done = 1'b1;
          if (data_q.size() > 0) ADC_Data = data_q.pop_front();
          else ADC_Data = W'($urandom);
          served = 1;
          done_q.push_back(cyc);
        end
      end else if (!ADC_Start) begin
        served   = 0;
        wait_cnt = 0;
        if (resp_spurious && $urandom_range(0, 49) == 0) begin
          ADC_Done = 1'b1;
          ADC_Data = W'($urandom);
        end
      end
    end
  end

  function automatic bit sig(input int which);
    case (which)
      0:       return ADC_Start;
      1:       return MAC_En;
      2:       return Salida_Valida;
      default: return Enable_Reg;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, input string name);
    int n;
    n = 0;
    while (!sig(which) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check(name, int'(sig(which)), 1);
  endtask

  task automatic clear_logs();
    en_q.delete(); tap_q.delete(); st_q.delete(); done_q.delete();
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
  endtask

  function automatic int outs_vec();
    return int'({ADC_Start, Enable_Reg, MAC_Clear, MAC_En, Salida_Valida, Overrun, Busy, Tap_Sel, Dato_Reg});
  endfunction

  initial begin : stimulus
    int c0;
    int n;
    logic [W-1:0] samples [3];
    samples[0] = 12'h001; samples[1] = 12'h002; samples[2] = 12'hFFF;

    // Reset held for 3 cycles: everything low.
    repeat (3) @(negedge CLK);
    check("reset_outputs", outs_vec(), 0);
    Reset = 1'b0;

    // First sample with a 5-cycle ADC.
    clear_logs();
    data_q.push_back(12'hA5C);
    resp_delay = 5;
    Run = 1'b1;
    c0 = cyc;
    @(negedge CLK);
    wait_for(0, 1100, "first_start_seen");
    check("first_start_cycle", cyc - c0, 1000);
    wait_for(2, 100, "first_valid_seen");
    check("first_latency", cyc - ((done_q.size() > 0) ? done_q[$] : -1000), 7);
    check("first_dato", int'(Dato_Reg), 'hA5C);
    @(negedge CLK);
    check("first_enable_count", en_q.size(), 1);
    check("first_tap_count", tap_q.size(), N_TAPS);
    for (int i = 0; i < tap_q.size(); i++) check("first_tap_seq", tap_q[i], i);

    // Three back-to-back periods.
    clear_logs();
    data_q.push_back(samples[0]); data_q.push_back(samples[1]); data_q.push_back(samples[2]);
    for (int i = 0; i < 3; i++) begin
      wait_for(2, 1100, "period_valid_seen");
      check("period_dato", int'(Dato_Reg), int'(samples[i]));
      @(negedge CLK);
    end
    check("period_enable_count", en_q.size(), 3);
    if (en_q.size() == 3) begin
      check("period_spacing_1", en_q[1] - en_q[0], DIV);
      check("period_spacing_2", en_q[2] - en_q[1], DIV);
    end
    check("period_no_overrun", int'(Overrun), 0);

`ifndef ADC_TIMEOUT_EN
    // Slow ADC: the tick during CONV is lost and flagged.
    clear_logs();
    resp_delay = 1200;
    wait_for(2, 2500, "slow_valid_seen");
    check("slow_overrun", int'(Overrun), 1);
    resp_delay = 5;
    @(negedge CLK);
    wait_for(2, 1100, "resume_valid_seen");
    check("resume_start_count", st_q.size(), 2);
    if (st_q.size() == 2) check("resume_start_spacing", st_q[1] - st_q[0], 2 * DIV);
`else
    // ADC never answers: give up after TO cycles, retry on the next tick.
    clear_logs();
    resp_delay = 0;
    wait_for(0, 1100, "to_start_seen");
    n = 0;
    while (ADC_Start && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("to_start_width", n, TO);
    check("to_error", int'(ADC_Error), 1);
    wait_for(0, 1100, "to_retry_seen");
    check("to_no_enable", en_q.size(), 0);
    if (st_q.size() == 2) check("to_retry_spacing", st_q[1] - st_q[0], DIV);
    else check("to_retry_count", st_q.size(), 2);
    resp_delay = 5;
`endif

    // Reset clears the sticky flag; then drop Run in the middle of MAC.
    Run = 1'b0;
    reset_dut();
    check("overrun_cleared", int'(Overrun), 0);
    Run = 1'b1;
    @(negedge CLK);
    wait_for(1, 1100, "drop_mac_seen");
    Run = 1'b0;
    wait_for(2, 20, "drop_valid_seen");
    @(negedge CLK);
    clear_logs();
    repeat (3000) @(negedge CLK);
    check("drop_no_start", st_q.size(), 0);
    check("drop_not_busy", int'(Busy), 0);

    // Reset in CONV, then again in MAC.
    resp_delay = 20;
    Run = 1'b1;
    @(negedge CLK);
    wait_for(0, 1100, "rst_conv_start_seen");
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    check("reset_in_conv", outs_vec(), 0);
    Reset = 1'b0;
    wait_for(1, 1100, "rst_mac_seen");
    Reset = 1'b1;
    @(negedge CLK);
    check("reset_in_mac", outs_vec(), 0);
    Reset = 1'b0;

    // Random traffic against the model.
    resp_spurious = 1;
    for (int it = 0; it < 30; it++) begin
      Run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) resp_delay = $urandom_range(900, 1300);
      else resp_delay = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) begin
        Reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        Reset = 1'b0;
      end
      repeat ($urandom_range(200, 1200)) @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #950000;
    errors++;
    $display("FAIL watchdog: got no end of run, expected finish before %0d cycles", 95000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
